// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and port/op constants for the memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchronizer for level signals from the memory clock domain
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter sequencing word requests onto the req/fin memory handshake
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic        a_err,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic        b_err,
  output logic [31:0] b_rdata,
  output logic        mem_wr_req,
  output logic        mem_rd_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_wr_fin,
  input  logic        mem_rd_fin,
  input  logic [31:0] mem_rd_data
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic          gnt_port;
  logic          op;
  logic          last;
  logic          armed;
  logic [CW-1:0] tcnt;
  logic          wr_fin_s, rd_fin_s, fin_s;

  logic          grant, finish, expire;
  logic          g_port, g_we;
  logic [31:0]   g_addr, g_wdata;

  sync_2ff u_wr_fin_sync (
    .clk   (clk),
    .reset (reset),
    .d     (mem_wr_fin),
    .q     (wr_fin_s)
  );

  sync_2ff u_rd_fin_sync (
    .clk   (clk),
    .reset (reset),
    .d     (mem_rd_fin),
    .q     (rd_fin_s)
  );

  assign fin_s = (op == OP_WR) ? wr_fin_s : rd_fin_s;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    finish    = 1'b0;
    expire    = 1'b0;
    g_port    = PORT_A;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
          if (a_req && b_req) g_port = (last == PORT_A) ? PORT_B : PORT_A;
          else if (a_req)     g_port = PORT_A;
          else                g_port = PORT_B;
        end
      end
      ISSUE: begin
        // A fin seen high before it has been seen low belongs to the previous op.
        if (armed && fin_s) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else if (tcnt == TLIM) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    g_we    = a_we;
    g_addr  = a_addr;
    g_wdata = a_wdata;
    if (g_port == PORT_B) begin
      g_we    = b_we;
      g_addr  = b_addr;
      g_wdata = b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt_port   <= PORT_A;
      op         <= OP_RD;
      last       <= PORT_B;
      armed      <= 1'b0;
      tcnt       <= '0;
      mem_wr_req <= 1'b0;
      mem_rd_req <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      a_ack      <= 1'b0;
      a_err      <= 1'b0;
      a_rdata    <= '0;
      b_ack      <= 1'b0;
      b_err      <= 1'b0;
      b_rdata    <= '0;
    end else begin
      a_ack <= 1'b0;
      a_err <= 1'b0;
      b_ack <= 1'b0;
      b_err <= 1'b0;

      if (grant) begin
        gnt_port   <= g_port;
        last       <= g_port;
        op         <= g_we ? OP_WR : OP_RD;
        armed      <= 1'b0;
        tcnt       <= '0;
        mem_addr   <= g_addr;
        mem_wdata  <= g_wdata;
        mem_wr_req <= g_we;
        mem_rd_req <= !g_we;
      end

      if (state == ISSUE) begin
        tcnt <= tcnt + 1'b1;
        if (!fin_s) armed <= 1'b1;
      end

      if (finish || expire) begin
        mem_wr_req <= 1'b0;
        mem_rd_req <= 1'b0;
        if (gnt_port == PORT_A) begin
          a_ack <= 1'b1;
          a_err <= expire;
        end else begin
          b_ack <= 1'b1;
          b_err <= expire;
        end
      end

      if (finish && op == OP_RD) begin
        if (gnt_port == PORT_A) a_rdata <= mem_rd_data;
        else                    b_rdata <= mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a slow big-endian memory model
module tb_mem_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        mclk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_wr_req, mem_rd_req;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wr_fin, mem_rd_fin;
  logic [31:0] mem_rd_data;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_ack       (a_ack),
    .a_err       (a_err),
    .a_rdata     (a_rdata),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_ack       (b_ack),
    .b_err       (b_err),
    .b_rdata     (b_rdata),
    .mem_wr_req  (mem_wr_req),
    .mem_rd_req  (mem_rd_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wr_fin  (mem_wr_fin),
    .mem_rd_fin  (mem_rd_fin),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;
  initial begin
    #2;
    forever #20 mclk = ~mclk;
  end

  // Memory model: accept on one mclk edge (fin cleared), complete on the next (fin set and held).
  logic [7:0]  mem [0:1023];
  int          mstate = 0;
  logic        m_wr_fin = 1'b0, m_rd_fin = 1'b0;
  logic [31:0] m_rd_data = '0;
  logic        m_we = 1'b0;
  logic [9:0]  m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic        tie_rd_low = 1'b0;

  assign mem_wr_fin  = m_wr_fin;
  assign mem_rd_fin  = m_rd_fin && !tie_rd_low;
  assign mem_rd_data = m_rd_data;

  always @(posedge mclk) begin
    if (mstate == 0) begin
      if (mem_wr_req || mem_rd_req) begin
        m_we     <= mem_wr_req;
        m_addr   <= mem_addr[9:0];
        m_wdata  <= mem_wdata;
        m_wr_fin <= 1'b0;
        m_rd_fin <= 1'b0;
        mstate   <= 1;
      end
    end else begin
      if (m_we) begin
        mem[m_addr]         <= m_wdata[31:24];
        mem[m_addr + 10'd1] <= m_wdata[23:16];
        mem[m_addr + 10'd2] <= m_wdata[15:8];
        mem[m_addr + 10'd3] <= m_wdata[7:0];
        m_wr_fin <= 1'b1;
      end else begin
        m_rd_data <= {mem[m_addr], mem[m_addr + 10'd1], mem[m_addr + 10'd2], mem[m_addr + 10'd3]};
        m_rd_fin  <= 1'b1;
      end
      mstate <= 0;
    end
  end

  logic a_ack_q = 1'b0, b_ack_q = 1'b0;
  logic overlap = 1'b0, wide = 1'b0;
  logic order [$];

  always @(negedge clk) begin
    a_ack_q <= a_ack;
    b_ack_q <= b_ack;
    if (mem_wr_req && mem_rd_req) overlap <= 1'b1;
    if ((a_ack && a_ack_q) || (b_ack && b_ack_q)) wide <= 1'b1;
    if (a_ack) order.push_back(1'b0);
    if (b_ack) order.push_back(1'b1);
  end

  int tests = 0;
  int fails = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input logic which, inout int lat, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if ((which == 1'b0 && a_ack) || (which == 1'b1 && b_ack)) ok = 1'b1;
    end
  endtask

  task automatic xfer(input string tag, input logic which, input logic we,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic err, output logic [31:0] rd);
    int   lat;
    logic ok;
    lat = 0;
    @(posedge clk); #1;
    if (which == 1'b0) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end
    wait_ack(which, lat, ok);
    check1({tag, "_ack"}, ok, 1'b1);
    err = (which == 1'b0) ? a_err : b_err;
    rd  = (which == 1'b0) ? a_rdata : b_rdata;
    @(posedge clk); #1;
    if (which == 1'b0) a_req = 1'b0;
    else               b_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  logic        er, ok;
  logic [31:0] rd;
  int          lat, n0, cnt, n;

  initial begin
    reset = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_ack_err", {28'd0, a_ack, b_ack, a_err, b_err}, 32'd0);
    check32("rst_mem_req", {30'd0, mem_wr_req, mem_rd_req}, 32'd0);
    check32("rst_mem_addr", mem_addr, 32'd0);
    check32("rst_mem_wdata", mem_wdata, 32'd0);
    check32("rst_a_rdata", a_rdata, 32'd0);
    check32("rst_b_rdata", b_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // A writes 0xDEADBEEF to 0x100 with both fins still low from reset
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h100; a_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check1("idle_no_req_yet", mem_wr_req, 1'b0);
    @(negedge clk);
    check1("grant_wr_req", mem_wr_req, 1'b1);
    check32("grant_addr", mem_addr, 32'h100);
    check32("grant_wdata", mem_wdata, 32'hDEADBEEF);
    lat = 2;
    wait_ack(1'b0, lat, ok);
    check1("w1_ack", ok, 1'b1);
    check1("w1_err", a_err, 1'b0);
    check1("w1_no_early_ack", lat >= 8, 1'b1);
    @(posedge clk); #1;
    a_req = 1'b0;
    check32("w1_mem_bytes", {mem[256], mem[257], mem[258], mem[259]}, 32'hDEADBEEF);

    xfer("r1", 1'b0, 1'b0, 32'h100, 32'h0, er, rd);
    check1("r1_err", er, 1'b0);
    check32("r1_rdata", rd, 32'hDEADBEEF);

    // Both ports request together after reset: A first, then strict alternation
    do_reset();
    @(posedge clk); #1;
    n0 = order.size();
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h100; a_wdata = 32'h0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h200; b_wdata = 32'hCAFEF00D;
    cnt = 0;
    for (int i = 0; i < 400 && cnt < 4; i++) begin
      @(negedge clk);
      if (a_ack || b_ack) cnt++;
    end
    check32("rr_ack_count", cnt, 32'd4);
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    repeat (3) @(posedge clk);
    check32("rr_order_len", order.size() - n0, 32'd4);
    if (order.size() - n0 >= 4) begin
      check32("rr_order", {28'd0, order[n0], order[n0+1], order[n0+2], order[n0+3]}, 32'b0101);
    end
    check32("rr_a_rdata", a_rdata, 32'hDEADBEEF);
    check32("rr_b_bytes", {mem[512], mem[513], mem[514], mem[515]}, 32'hCAFEF00D);

    // B writes 0x40, A reads it straight back
    xfer("bw", 1'b1, 1'b1, 32'h40, 32'h12345678, er, rd);
    check1("bw_err", er, 1'b0);
    xfer("ar", 1'b0, 1'b0, 32'h40, 32'h0, er, rd);
    check1("ar_err", er, 1'b0);
    check32("ar_rdata", rd, 32'h12345678);
    check32("b_rdata_untouched_by_writes", b_rdata, 32'd0);

    // Read fin held low: error ack after exactly TO cycles in ISSUE
    tie_rd_low = 1'b1;
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h40; b_wdata = 32'h0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (mem_rd_req) ok = 1'b1;
    end
    check1("to_issue_seen", ok, 1'b1);
    n = 1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (b_ack) ok = 1'b1;
      else if (mem_rd_req) n++;
    end
    check1("to_ack", ok, 1'b1);
    check32("to_issue_cycles", n, TO);
    check1("to_err", b_err, 1'b1);
    check1("to_req_dropped", mem_rd_req, 1'b0);
    check32("to_rdata_zero", b_rdata, 32'd0);
    @(posedge clk); #1;
    b_req = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    tie_rd_low = 1'b0;
    repeat (20) @(posedge clk);

    // Reset while in ISSUE aborts silently
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h100; a_wdata = 32'h0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (mem_rd_req) ok = 1'b1;
    end
    check1("ab_issue_seen", ok, 1'b1);
    @(posedge clk); #1;
    n0 = order.size();
    reset = 1'b0;
    a_req = 1'b0;
    @(negedge clk);
    check1("ab_still_issuing", mem_rd_req, 1'b1);
    @(negedge clk);
    check32("ab_mem_req_off", {30'd0, mem_wr_req, mem_rd_req}, 32'd0);
    check1("ab_no_ack", a_ack, 1'b0);
    check32("ab_rdata_cleared", a_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    check32("ab_no_late_ack", order.size() - n0, 32'd0);

    xfer("re", 1'b0, 1'b0, 32'h100, 32'h0, er, rd);
    check1("re_err", er, 1'b0);
    check32("re_rdata", rd, 32'hDEADBEEF);

    check1("never_both_mem_req", overlap, 1'b0);
    check1("ack_single_cycle", wide, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter and sequencer in front of the byte-addressed simulation memory. It accepts word read/write requests from two requesters, port A (instruction fetch) and port B (data/GC), and serialises them onto the memory's level-held `req`/`fin` interface. It runs that handshake across the clock boundary and returns a one-cycle `ack` with read data to the granted requester. It sits between the CPU front end and the memory model.

## Interface
- `TIMEOUT`, default 1024: clk cycles allowed from issue to completion before an error ack.
- `clk` input, 1 bit: arbiter clock, rising edge.
- `reset` input, 1 bit: synchronous, active-low.
- `a_req`, `b_req` input, 1 bit each: request. Held high, with `we`, `addr` and `wdata`, stable until `ack`.
- `a_we`, `b_we` input, 1 bit each: 1 = write, 0 = read.
- `a_addr`, `b_addr` input, 32 bits each: byte address of a big-endian word.
- `a_wdata`, `b_wdata` input, 32 bits each: write data.
- `a_ack`, `b_ack` output, 1 bit each: one-cycle completion pulse.
- `a_err`, `b_err` output, 1 bit each: valid with `ack`; 1 = timed out.
- `a_rdata`, `b_rdata` output, 32 bits each: read data, valid with `ack`, held until the next ack on that port.
- `mem_wr_req`, `mem_rd_req` output, 1 bit each: to memory. Never both high.
- `mem_addr`, `mem_wdata` output, 32 bits each: to memory, stable while either req is high.
- `mem_wr_fin`, `mem_rd_fin` input, 1 bit each: from memory. Asynchronous to `clk`, level.
- `mem_rd_data` input, 32 bits: from memory, stable while `mem_rd_fin` is high.

## Operation
- Reset (`reset`=0 at a clk edge): state IDLE, all `ack`/`err`/`mem_*_req` 0, `rdata` 0, `mem_addr`/`mem_wdata` 0, `last`=B so A wins first, `armed` 0, timeout counter 0.
- Both fin inputs pass through 2-flop synchronizers (`wr_fin_s`, `rd_fin_s`). The fin used in a transaction is the one matching the latched op.
- **IDLE:**
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the port other than `last`.
  - On grant, latch port, op, addr and wdata into `mem_addr`/`mem_wdata`, set `last`, clear `armed`, and move to ISSUE.
- **ISSUE:**
  - Drive the matching `mem_*_req`=1.
  - `armed` is set in any cycle where the synced fin is 0. The memory clears fin on acceptance, and fin is already 0 on the first transaction.
  - When `armed`=1 and synced fin=1, drop the req, capture `mem_rd_data` on reads, and move to DONE.
- **DONE:** pulse the granted port's `ack` for one cycle with `err`=0, then go to IDLE.
- **Timeout:** the counter increments every ISSUE cycle. If it reaches `TIMEOUT`, drop the req, pulse `ack` with `err`=1, leave `rdata` at 0, and go to IDLE. A timeout is a fatal integration error; behaviour of later transactions is undefined.
- **Reset mid-transaction:** the arbiter aborts immediately with no ack, `mem_*_req` goes to 0 on the next edge, and the requester must re-issue.
- **Integration constraint:** the clk period must be at most one quarter of the memory clock period (bench: clk period 10, memory period 40). This lets req drop before the memory's next IDLE sample and prevents a duplicate issue.

## Timing
- Grant latency: req seen in IDLE → ISSUE on the next edge.
- Minimum ack latency: memory round trip plus 2 sync cycles plus 2 cycles (ISSUE exit, DONE).
- `ack` is high for exactly one cycle. The requester may drop req the cycle after ack, or keep it high to request again. A re-request is eligible in the IDLE cycle that follows.
- Back-to-back: after DONE, IDLE takes one cycle before the next grant.
- Fairness: with both ports continuously requesting, grants alternate A, B, A, B.

## Structure
- Package `mem_arb_pkg`: state encoding (IDLE, ISSUE, DONE), port index constants `PORT_A`/`PORT_B`, op constants `OP_RD`/`OP_WR`.
- Sub-module `sync_2ff`: a 1-bit two-flop synchronizer, instantiated for `mem_wr_fin` and `mem_rd_fin`. It resets to 0 on the same reset.
- Top module contains the FSM, round-robin pointer, latches and timeout counter.

## Test plan
- Reset, A writes 0xDEADBEEF to 0x100, then A reads 0x100 → the write ack has `err`=0; the read ack returns `a_rdata`=0xDEADBEEF; the memory bytes are 0xDE, 0xAD, 0xBE, 0xEF.
- A and B raise req in the same cycle after reset → A is granted first, then B. With both held high for 4 transactions, the grant order is A, B, A, B.
- Write via B, then immediately read via A of the same address 0x40 with value 0x12345678 → A gets 0x12345678. Each `ack` is exactly one cycle and `mem_wr_req`/`mem_rd_req` are never high together.
- Tie `mem_rd_fin` low and set `TIMEOUT`=16, then B reads → `b_ack`=1 and `b_err`=1 exactly 16 ISSUE cycles later; `mem_rd_req` drops on the same edge.
- Assert reset while in ISSUE → the next edge gives IDLE with `mem_*_req`=0 and no ack. A fresh A read then completes normally.
- The first transaction after reset has both fin signals at 0, and it still waits for the fin 0→1 edge → no early ack.
